// File: rtl/sd_upsizer.sv
// sd_upsizer: srdy/drdy width upsizer. Packs `ratio` narrow words into one
// wide word (lane 0 in the LSBs), closing early on end-of-packet.
// Optional feature: define SD_UPSIZER_TIMEOUT_EN to flush a partial word
// after `timeout` idle cycles.
module sd_upsizer #(
  parameter int in_width  = 8,
  parameter int ratio     = 4,
  parameter int out_width = in_width * ratio,
  parameter int cnt_sz    = $clog2(ratio + 1)
`ifdef SD_UPSIZER_TIMEOUT_EN
  ,
  parameter int timeout   = 16
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [in_width-1:0]  c_data,
  input  logic                 c_eop,
  input  logic                 c_srdy,
  output logic                 c_drdy,
  output logic [out_width-1:0] p_data,
  output logic [cnt_sz-1:0]    p_cnt,
  output logic                 p_eop,
  output logic                 p_srdy,
  input  logic                 p_drdy
);

  typedef enum logic {ACC_OPEN, ACC_CLOSED} acc_state_t;

  acc_state_t           state, n_state;
  logic [out_width-1:0] acc, n_acc, merged, ld_data;
  logic [cnt_sz-1:0]    acc_cnt, n_cnt, ld_cnt;
  logic                 acc_eop, n_acc_eop, ld_eop;
  logic [out_width-1:0] n_p_data;
  logic [cnt_sz-1:0]    n_p_cnt;
  logic                 n_p_eop, n_p_srdy;
  logic                 in_xfer, out_free, close_in, flush;

  assign c_drdy   = (state == ACC_OPEN);
  assign in_xfer  = c_srdy & c_drdy;
  assign out_free = ~p_srdy | p_drdy;
  assign close_in = in_xfer & (c_eop | (acc_cnt == cnt_sz'(ratio - 1)));

`ifdef SD_UPSIZER_TIMEOUT_EN
  localparam int idle_sz = $clog2(timeout + 1);
  logic [idle_sz-1:0] idle_cnt;
  logic               idle;

  assign idle  = (acc_cnt != '0) & (state == ACC_OPEN) & ~in_xfer;
  assign flush = idle & (idle_cnt == idle_sz'(timeout - 1));

  // Idle cycle counter for the partial-word flush
  always_ff @(posedge clk) begin
    if (reset || !idle || flush) idle_cnt <= '0;
    else                         idle_cnt <= idle_cnt + idle_sz'(1);
  end
`else
  assign flush = 1'b0;
`endif

  // Place the incoming word into lane acc_cnt of the accumulator
  always_comb begin
    merged = acc;
    for (int unsigned i = 0; i < ratio; i++) begin
      if (acc_cnt == cnt_sz'(i)) merged[i*in_width +: in_width] = c_data;
    end
  end

  // Next-state for accumulator and output register
  always_comb begin
    n_state   = state;
    n_acc     = acc;
    n_cnt     = acc_cnt;
    n_acc_eop = acc_eop;
    n_p_data  = p_data;
    n_p_cnt   = p_cnt;
    n_p_eop   = p_eop;
    n_p_srdy  = p_srdy & ~p_drdy;
    ld_data   = close_in ? merged : acc;
    ld_cnt    = close_in ? acc_cnt + cnt_sz'(1) : acc_cnt;
    ld_eop    = close_in & c_eop;

    if (state == ACC_CLOSED) begin
      // acc_cnt holds the full lane count while closed; it is reopened at 0
      if (out_free) begin
        n_p_data  = acc;
        n_p_cnt   = acc_cnt;
        n_p_eop   = acc_eop;
        n_p_srdy  = 1'b1;
        n_acc     = '0;
        n_cnt     = '0;
        n_acc_eop = 1'b0;
        n_state   = ACC_OPEN;
      end
    end else if (close_in || flush) begin
      if (out_free) begin
        n_p_data  = ld_data;
        n_p_cnt   = ld_cnt;
        n_p_eop   = ld_eop;
        n_p_srdy  = 1'b1;
        n_acc     = '0;
        n_cnt     = '0;
        n_acc_eop = 1'b0;
      end else begin
        n_acc     = ld_data;
        n_cnt     = ld_cnt;
        n_acc_eop = ld_eop;
        n_state   = ACC_CLOSED;
      end
    end else if (in_xfer) begin
      n_acc = merged;
      n_cnt = acc_cnt + cnt_sz'(1);
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ACC_OPEN;
      acc     <= '0;
      acc_cnt <= '0;
      acc_eop <= 1'b0;
      p_data  <= '0;
      p_cnt   <= '0;
      p_eop   <= 1'b0;
      p_srdy  <= 1'b0;
    end else begin
      state   <= n_state;
      acc     <= n_acc;
      acc_cnt <= n_cnt;
      acc_eop <= n_acc_eop;
      p_data  <= n_p_data;
      p_cnt   <= n_p_cnt;
      p_eop   <= n_p_eop;
      p_srdy  <= n_p_srdy;
    end
  end

endmodule
